// File: rtl/inst_queue_pkg.sv
// Shared constants for the fetch-to-decode instruction queue: word widths,
// immediate-format encodings and the RV32 opcodes that select them.
package inst_queue_pkg;

   localparam int INSN_LEN       = 32;
   localparam int ADDR_LEN       = 32;
   localparam int IMM_TYPE_WIDTH = 2;

   typedef enum logic [IMM_TYPE_WIDTH-1:0] {
      IMM_I = 2'd0,
      IMM_S = 2'd1,
      IMM_U = 2'd2,
      IMM_J = 2'd3
   } imm_type_e;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef struct packed {
      logic [INSN_LEN-1:0] inst;
      logic [ADDR_LEN-1:0] pc;
      imm_type_e           imm_type;
   } iq_entry_t;

   localparam int ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode handshake bundle of the instruction queue; the queue uses the
// slave view, the fetch/decode environment the master view.
interface inst_queue_if #(
   parameter int DEPTH = 8
) ();
   import inst_queue_pkg::*;

   logic                      enq_valid;
   logic                      enq_ready;
   logic [INSN_LEN-1:0]       enq_inst;
   logic [ADDR_LEN-1:0]       enq_pc;
   logic                      deq_valid;
   logic                      deq_ready;
   logic [INSN_LEN-1:0]       deq_inst;
   logic [ADDR_LEN-1:0]       deq_pc;
   logic [IMM_TYPE_WIDTH-1:0] deq_imm_type;
   logic [$clog2(DEPTH):0]    count;

   modport master (
      output enq_valid, enq_inst, enq_pc, deq_ready,
      input  enq_ready, deq_valid, deq_inst, deq_pc, deq_imm_type, count
   );

   modport slave (
      input  enq_valid, enq_inst, enq_pc, deq_ready,
      output enq_ready, deq_valid, deq_inst, deq_pc, deq_imm_type, count
   );

endinterface

// File: rtl/inst_queue_imm_type_predec.sv
// Combinational opcode-to-immediate-format map, shared by the instruction
// queue and the decoder.
module imm_type_predec
   import inst_queue_pkg::*;
(
   input  logic [6:0] opcode,
   output imm_type_e  imm_type
);

   // Opcode classification; anything unrecognised uses the I-format.
   always_comb begin
      imm_type = IMM_I;
      case (opcode)
         OP_LUI, OP_AUIPC: imm_type = IMM_U;
         OP_JAL:           imm_type = IMM_J;
         OP_STORE:         imm_type = IMM_S;
         default:          imm_type = IMM_I;
      endcase
   end

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO with enqueue-time immediate pre-decode.
// Define INST_QUEUE_BYPASS_EN for zero-cycle pass-through when empty.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   inst_queue_if.slave q
);

   localparam int             PTR_W     = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0] EMPTY_CNT = {(PTR_W+1){1'b0}};
   localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   iq_entry_t        mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [PTR_W:0]   count_r;
   logic [PTR_W:0]   count_nxt_s;
   logic             enq_ready_r;
   logic             deq_valid_r;
   logic             push_s;
   logic             pop_s;
   imm_type_e        enq_imm_type_s;
   iq_entry_t        enq_entry_s;
   iq_entry_t        head_s;
`ifdef INST_QUEUE_BYPASS_EN
   logic             bypass_s;
`endif

   imm_type_predec u_predec (
      .opcode   (q.enq_inst[6:0]),
      .imm_type (enq_imm_type_s)
   );

   assign enq_entry_s = '{inst: q.enq_inst, pc: q.enq_pc, imm_type: enq_imm_type_s};
   assign head_s      = mem_r[rd_ptr_r];

   // Handshake decode and next occupancy.
   always_comb begin
      push_s = q.enq_valid & enq_ready_r;
      pop_s  = deq_valid_r & q.deq_ready;
`ifdef INST_QUEUE_BYPASS_EN
      bypass_s = (count_r == EMPTY_CNT) & q.enq_valid & ~flush;
      if (bypass_s && q.deq_ready) begin
         push_s = 1'b0;
      end else begin
         push_s = q.enq_valid & enq_ready_r;
      end
`endif
      count_nxt_s = count_r;
      if (push_s && !pop_s) begin
         count_nxt_s = count_r + ONE_CNT;
      end else if (pop_s && !push_s) begin
         count_nxt_s = count_r - ONE_CNT;
      end else begin
         count_nxt_s = count_r;
      end
   end

   // Storage, pointers and registered status flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {ENTRY_W{1'b0}};
         end
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         count_r     <= EMPTY_CNT;
         enq_ready_r <= 1'b1;
         deq_valid_r <= 1'b0;
      end else if (flush) begin
         // Entries are left in place; only the bookkeeping is dropped.
         wr_ptr_r    <= PTR_ZERO;
         rd_ptr_r    <= PTR_ZERO;
         count_r     <= EMPTY_CNT;
         enq_ready_r <= 1'b1;
         deq_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= enq_entry_s;
            wr_ptr_r        <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r     <= count_nxt_s;
         enq_ready_r <= (count_nxt_s != FULL_CNT);
         deq_valid_r <= (count_nxt_s != EMPTY_CNT);
      end
   end

   // Dequeue-side view: head entry, or the incoming word when bypassing.
   always_comb begin
      q.deq_valid    = deq_valid_r;
      q.deq_inst     = head_s.inst;
      q.deq_pc       = head_s.pc;
      q.deq_imm_type = head_s.imm_type;
`ifdef INST_QUEUE_BYPASS_EN
      if (bypass_s) begin
         q.deq_valid    = 1'b1;
         q.deq_inst     = q.enq_inst;
         q.deq_pc       = q.enq_pc;
         q.deq_imm_type = enq_imm_type_s;
      end else begin
         q.deq_valid    = deq_valid_r;
         q.deq_inst     = head_s.inst;
         q.deq_pc       = head_s.pc;
         q.deq_imm_type = head_s.imm_type;
      end
`endif
   end

   assign q.enq_ready = enq_ready_r;
   assign q.count     = count_r;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_inst_queue;

   localparam int DEPTH = 8;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [1:0]  t;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   ent_t mq[$];

   inst_queue_if #(.DEPTH(DEPTH)) qif ();

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .q     (qif)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_type(input logic [31:0] inst);
      logic [6:0] op;
      op = inst[6:0];
      if (op == 7'h37 || op == 7'h17) return 2'd2;
      else if (op == 7'h6F) return 2'd3;
      else if (op == 7'h23) return 2'd1;
      else return 2'd0;
   endfunction

   // One clock with the given inputs; the model follows the queue rules.
   task automatic step(input logic ev, input logic [31:0] inst, input logic [31:0] pc,
                       input logic dr, input logic fl);
      ent_t e;
      logic efire, dfire, byp;
      qif.enq_valid = ev;
      qif.enq_inst  = inst;
      qif.enq_pc    = pc;
      qif.deq_ready = dr;
      flush         = fl;
      e.inst = inst;
      e.pc   = pc;
      e.t    = ref_type(inst);
      byp = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
      byp = (mq.size() == 0) && ev && !fl;
`endif
      efire = ev && (mq.size() != DEPTH);
      dfire = dr && (mq.size() != 0);
      @(posedge clk);
      if (fl) mq.delete();
      else if (byp && dr) begin
      end else begin
         if (dfire) void'(mq.pop_front());
         if (efire) mq.push_back(e);
      end
      #1;
      qif.enq_valid = 1'b0;
      qif.deq_ready = 1'b0;
      flush         = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      qif.enq_valid = 1'b0;
      qif.enq_inst  = 32'h0;
      qif.enq_pc    = 32'h0;
      qif.deq_ready = 1'b0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      mq.delete();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (qif.deq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_deq_valid got %0b exp 0", qif.deq_valid); end
      n_checks++; if (qif.enq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ready got %0b exp 1", qif.enq_ready); end
      n_checks++; if (qif.count !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", qif.count); end
      n_checks++; if (qif.deq_imm_type !== 2'd0) begin n_fail++; $display("FAIL reset_imm_type got %0d exp 0", qif.deq_imm_type); end
      n_checks++; if (qif.deq_inst !== 32'h0 || qif.deq_pc !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", qif.deq_inst, qif.deq_pc); end
   endtask

   task automatic test_order();
      step(1'b1, 32'h123452B7, 32'h100, 1'b0, 1'b0);
      n_checks++; if (qif.deq_valid !== 1'b1) begin n_fail++; $display("FAIL latency_deq_valid got %0b exp 1", qif.deq_valid); end
      step(1'b1, 32'h008000EF, 32'h104, 1'b0, 1'b0);
      n_checks++; if (qif.count !== 4'd2) begin n_fail++; $display("FAIL order_count got %0d exp 2", qif.count); end
      n_checks++; if (qif.deq_inst !== 32'h123452B7 || qif.deq_pc !== 32'h100) begin n_fail++; $display("FAIL order_head0 got %h/%h exp 123452b7/100", qif.deq_inst, qif.deq_pc); end
      n_checks++; if (qif.deq_imm_type !== 2'd2) begin n_fail++; $display("FAIL order_type0 got %0d exp 2", qif.deq_imm_type); end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (qif.deq_inst !== 32'h008000EF || qif.deq_pc !== 32'h104) begin n_fail++; $display("FAIL order_head1 got %h/%h exp 008000ef/104", qif.deq_inst, qif.deq_pc); end
      n_checks++; if (qif.deq_imm_type !== 2'd3) begin n_fail++; $display("FAIL order_type1 got %0d exp 3", qif.deq_imm_type); end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      n_checks++; if (qif.count !== 4'd0 || qif.deq_valid !== 1'b0) begin n_fail++; $display("FAIL order_empty got cnt %0d v %0b exp 0/0", qif.count, qif.deq_valid); end
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 32'h00000013 + (i << 20), 32'h200 + 4 * i, 1'b0, 1'b0);
      n_checks++; if (qif.count !== 4'd8 || qif.enq_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got cnt %0d rdy %0b exp 8/0", qif.count, qif.enq_ready); end
      step(1'b1, 32'hDEAD0013, 32'h300, 1'b0, 1'b0);
      n_checks++; if (qif.count !== 4'd8) begin n_fail++; $display("FAIL full_ninth got %0d exp 8", qif.count); end
      step(1'b1, 32'hBEEF0013, 32'h304, 1'b1, 1'b0);
      n_checks++; if (qif.count !== 4'd7 || qif.enq_ready !== 1'b1) begin n_fail++; $display("FAIL full_poppush got cnt %0d rdy %0b exp 7/1", qif.count, qif.enq_ready); end
      for (int i = 1; i < DEPTH; i++) begin
         n_checks++; if (qif.deq_inst !== mq[0].inst || qif.deq_pc !== 32'h200 + 4 * i) begin n_fail++; $display("FAIL full_drain%0d got %h/%h exp %h/%h", i, qif.deq_inst, qif.deq_pc, mq[0].inst, 32'h200 + 4 * i); end
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      end
      n_checks++; if (qif.count !== 4'd0) begin n_fail++; $display("FAIL full_drained got %0d exp 0", qif.count); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w;
      for (int i = 0; i < 20; i++) begin
         w = 32'h00001037 + (i << 12) + (i << 7);
         if (i > 0) begin
            n_checks++; if (mq.size() != 1 || qif.deq_inst !== mq[0].inst || qif.deq_pc !== mq[0].pc) begin n_fail++; $display("FAIL b2b_head%0d got %h exp %h", i, qif.deq_inst, (mq.size() > 0) ? mq[0].inst : 32'h0); end
         end
         step(1'b1, w, 32'h1000 + 4 * i, i > 0, 1'b0);
         n_checks++; if (qif.count !== 4'd1) begin n_fail++; $display("FAIL b2b_count%0d got %0d exp 1", i, qif.count); end
      end
      n_checks++; if (qif.deq_pc !== 32'h1000 + 4 * 19) begin n_fail++; $display("FAIL b2b_last got %h exp %h", qif.deq_pc, 32'h1000 + 4 * 19); end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) step(1'b1, 32'h00A00093 + i, 32'h400 + 4 * i, 1'b0, 1'b0);
      n_checks++; if (qif.count !== 4'd5) begin n_fail++; $display("FAIL flush_pre got %0d exp 5", qif.count); end
      step(1'b1, 32'h0BAD0023, 32'h500, 1'b0, 1'b1);
      n_checks++; if (qif.count !== 4'd0 || qif.deq_valid !== 1'b0 || qif.enq_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got cnt %0d v %0b r %0b exp 0/0/1", qif.count, qif.deq_valid, qif.enq_ready); end
      step(1'b1, 32'h12300067, 32'h600, 1'b0, 1'b0);
      n_checks++; if (qif.deq_inst !== 32'h12300067 || qif.deq_pc !== 32'h600 || qif.count !== 4'd1) begin n_fail++; $display("FAIL flush_after got %h/%h exp 12300067/600", qif.deq_inst, qif.deq_pc); end
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
   endtask

`ifdef INST_QUEUE_BYPASS_EN
   task automatic test_bypass();
      qif.enq_valid = 1'b1;
      qif.enq_inst  = 32'h00A12023;
      qif.enq_pc    = 32'h700;
      qif.deq_ready = 1'b1;
      #1;
      n_checks++; if (qif.deq_valid !== 1'b1 || qif.deq_inst !== 32'h00A12023) begin n_fail++; $display("FAIL bypass_data got v %0b %h exp 1/00a12023", qif.deq_valid, qif.deq_inst); end
      n_checks++; if (qif.deq_imm_type !== 2'd1) begin n_fail++; $display("FAIL bypass_type got %0d exp 1", qif.deq_imm_type); end
      step(1'b1, 32'h00A12023, 32'h700, 1'b1, 1'b0);
      n_checks++; if (qif.count !== 4'd0 || qif.deq_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_count got %0d exp 0", qif.count); end
   endtask
`endif

   task automatic test_random();
      logic [6:0]  ops [5];
      logic [31:0] r;
      logic        ev, dr, fl;
      ops[0] = 7'h37; ops[1] = 7'h17; ops[2] = 7'h6F; ops[3] = 7'h23; ops[4] = 7'h13;
      for (int i = 0; i < 300; i++) begin
         r  = $urandom;
         ev = ($urandom_range(0, 3) != 0);
         dr = ($urandom_range(0, 2) == 0);
         fl = ($urandom_range(0, 29) == 0);
         step(ev, {r[31:7], ops[$urandom_range(0, 4)]}, $urandom, dr, fl);
         n_checks++; if (qif.count !== 4'(mq.size()) || qif.enq_ready !== (mq.size() != DEPTH) || qif.deq_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_status%0d got cnt %0d r %0b v %0b exp cnt %0d", i, qif.count, qif.enq_ready, qif.deq_valid, mq.size()); end
         if (mq.size() != 0) begin
            n_checks++; if (qif.deq_inst !== mq[0].inst || qif.deq_pc !== mq[0].pc || qif.deq_imm_type !== mq[0].t) begin n_fail++; $display("FAIL rand_head%0d got %h/%h/%0d exp %h/%h/%0d", i, qif.deq_inst, qif.deq_pc, qif.deq_imm_type, mq[0].inst, mq[0].pc, mq[0].t); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_order();
      test_full();
      test_back_to_back();
      test_flush();
`ifdef INST_QUEUE_BYPASS_EN
      test_bypass();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
